// File: rtl/cla_adder_pkg.sv
// Shared types and constants for the registered carry-look-ahead adder.
// Holds the look-ahead group size and the per-group generate/propagate bundle.
package cla_adder_pkg;

    localparam int CLA_GROUP = 4;

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] p;
    } gp4_t;

endpackage

// File: rtl/cla_adder_grp4.sv
// Combinational 4-bit carry-look-ahead group with flattened carry equations.
// Ports: a, b (4-bit operands), ci (group carry-in); s (sum), G/P (group
// generate/propagate), co (group carry-out).
module cla_adder_grp4
    import cla_adder_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       G,
    output logic       P,
    output logic       co
);

    gp4_t       gp;
    logic [3:0] c;

    assign gp.g = a & b;
    assign gp.p = a ^ b;

    // Every internal carry is a two-level function of ci and g/p terms.
    assign c[0] = ci;
    assign c[1] = gp.g[0]
                | (gp.p[0] & ci);
    assign c[2] = gp.g[1]
                | (gp.p[1] & gp.g[0])
                | (gp.p[1] & gp.p[0] & ci);
    assign c[3] = gp.g[2]
                | (gp.p[2] & gp.g[1])
                | (gp.p[2] & gp.p[1] & gp.g[0])
                | (gp.p[2] & gp.p[1] & gp.p[0] & ci);

    assign G = gp.g[3]
             | (gp.p[3] & gp.g[2])
             | (gp.p[3] & gp.p[2] & gp.g[1])
             | (gp.p[3] & gp.p[2] & gp.p[1] & gp.g[0]);
    assign P  = &gp.p;
    assign co = G | (P & ci);

    assign s = gp.p ^ c;

endmodule

// File: rtl/cla_adder.sv
// Registered carry-look-ahead adder: {cout,sum} = a + b + cin, one cycle later.
// Ports: clk, rst (sync, active-high), in_valid, a, b, cin; sum, cout,
// out_valid, and ovf (signed overflow) when CLA_ADDER_OVF_EN is defined.
module cla_adder
    import cla_adder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
`ifdef CLA_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NG = WIDTH / CLA_GROUP;

    generate
        if (WIDTH <= 0 || (WIDTH % CLA_GROUP) != 0) begin : g_bad_width
            $error("cla_adder: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    logic [NG:0]      carry;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [WIDTH-1:0] sum_c;

    assign carry[0] = cin;

    // Group carry-out is G | P & ci, so chaining co is the group-level chain.
    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_adder_grp4 u_grp (
            .a  (a[k*CLA_GROUP +: CLA_GROUP]),
            .b  (b[k*CLA_GROUP +: CLA_GROUP]),
            .ci (carry[k]),
            .s  (sum_c[k*CLA_GROUP +: CLA_GROUP]),
            .G  (grp_g[k]),
            .P  (grp_p[k]),
            .co (carry[k+1])
        );
    end

    logic unused_gp;
    assign unused_gp = ^{grp_g, grp_p};

`ifdef CLA_ADDER_OVF_EN
    // Carry into the MSB recovered from the MSB sum bit.
    logic c_msb;
    assign c_msb = a[WIDTH-1] ^ b[WIDTH-1] ^ sum_c[WIDTH-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
`ifdef CLA_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_c;
                cout <= carry[NG];
`ifdef CLA_ADDER_OVF_EN
                ovf  <= c_msb ^ carry[NG];
`endif
            end
        end
    end

endmodule

// File: tb/tb_cla_adder.sv
// Scoreboard bench for cla_adder at WIDTH=4 and WIDTH=16.
// Expected results are queued on drive and compared when out_valid rises.
module tb_cla_adder;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        v4, v16;
    logic [3:0]  a4, b4;
    logic [15:0] a16, b16;
    logic        cin4, cin16;
    logic [3:0]  sum4;
    logic [15:0] sum16;
    logic        cout4, cout16;
    logic        ov4, ov16;
`ifdef CLA_ADDER_OVF_EN
    logic        ovf4, ovf16;
`endif

    int n_vec = 0;
    int n_err = 0;

    exp_t q4[$];
    exp_t q16[$];
    exp_t e4, e16;

    always #5 clk = ~clk;

    cla_adder #(.WIDTH(4)) u4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .sum       (sum4),
        .cout      (cout4),
        .out_valid (ov4)
`ifdef CLA_ADDER_OVF_EN
        ,
        .ovf       (ovf4)
`endif
    );

    cla_adder #(.WIDTH(16)) u16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v16),
        .a         (a16),
        .b         (b16),
        .cin       (cin16),
        .sum       (sum16),
        .cout      (cout16),
        .out_valid (ov16)
`ifdef CLA_ADDER_OVF_EN
        ,
        .ovf       (ovf16)
`endif
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] x,
                                   input logic [15:0] y,
                                   input logic ci,
                                   input int w);
        exp_t        e;
        logic [16:0] t;
        int          m;
        m   = w - 1;
        t   = {1'b0, x} + {1'b0, y} + {16'b0, ci};
        e.s = (w == 4) ? {12'b0, t[3:0]} : t[15:0];
        e.c = t[w];
        e.o = (x[m] == y[m]) && (t[m] != x[m]);
        return e;
    endfunction

    task automatic drive4(input logic [3:0] x, input logic [3:0] y,
                          input logic ci, input exp_t e);
        @(negedge clk);
        a4 = x; b4 = y; cin4 = ci; v4 = 1'b1;
        q4.push_back(e);
    endtask

    task automatic drive16(input logic [15:0] x, input logic [15:0] y,
                           input logic ci);
        @(negedge clk);
        a16 = x; b16 = y; cin16 = ci; v16 = 1'b1;
        q16.push_back(model(x, y, ci, 16));
    endtask

    function automatic exp_t mk(input logic [3:0] s, input logic c);
        exp_t e;
        e.s = {12'b0, s};
        e.c = c;
        e.o = 1'b0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (ov4) begin
            if (q4.size() == 0) begin
                chk("q4_unexpected", 32'd1, 32'd0);
            end else begin
                e4 = q4.pop_front();
                chk("sum4", {28'b0, sum4}, {28'b0, e4.s[3:0]});
                chk("cout4", {31'b0, cout4}, {31'b0, e4.c});
`ifdef CLA_ADDER_OVF_EN
                chk("ovf4", {31'b0, ovf4}, {31'b0, e4.o});
`endif
            end
        end
        if (ov16) begin
            if (q16.size() == 0) begin
                chk("q16_unexpected", 32'd1, 32'd0);
            end else begin
                e16 = q16.pop_front();
                chk("sum16", {16'b0, sum16}, {16'b0, e16.s});
                chk("cout16", {31'b0, cout16}, {31'b0, e16.c});
`ifdef CLA_ADDER_OVF_EN
                chk("ovf16", {31'b0, ovf16}, {31'b0, e16.o});
`endif
            end
        end
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic [3:0] s;
        logic       c;
    } vec_t;

    vec_t tbl[11] = '{
        '{4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0},
        '{4'b0010, 4'b0110, 1'b0, 4'b1000, 1'b0},
        '{4'b0111, 4'b0111, 1'b0, 4'b1110, 1'b0},
        '{4'b1001, 4'b0110, 1'b0, 4'b1111, 1'b0},
        '{4'b1100, 4'b1100, 1'b0, 4'b1000, 1'b1},
        '{4'b1111, 4'b1110, 1'b0, 4'b1101, 1'b1},
        '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1},
        '{4'b1110, 4'b1110, 1'b1, 4'b1101, 1'b1},
        '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1},
        '{4'b1010, 4'b1010, 1'b1, 4'b0101, 1'b1},
        '{4'b1101, 4'b1000, 1'b1, 4'b0110, 1'b1}
    };

    initial begin
        logic [8:0] idx;
        exp_t       e;
        rst = 1'b1;
        v4 = 1'b0; v16 = 1'b0;
        a4 = '0; b4 = '0; cin4 = 1'b0;
        a16 = '0; b16 = '0; cin16 = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sum", {28'b0, sum4}, 32'd0);
        chk("rst_cout", {31'b0, cout4}, 32'd0);
        chk("rst_valid", {31'b0, ov4}, 32'd0);
        chk("rst_sum16", {16'b0, sum16}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_sum", {28'b0, sum4}, 32'd0);
        chk("idle_valid", {31'b0, ov4}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            e = mk(tbl[i].s, tbl[i].c);
            e.o = model({12'b0, tbl[i].a}, {12'b0, tbl[i].b},
                        tbl[i].ci, 4).o;
            drive4(tbl[i].a, tbl[i].b, tbl[i].ci, e);
        end

        drive4(4'b0111, 4'b0111, 1'b0, mk(4'b1110, 1'b0));
        @(negedge clk);
        v4 = 1'b0;
        @(negedge clk);
        chk("hold_sum", {28'b0, sum4}, 32'he);
        chk("hold_valid", {31'b0, ov4}, 32'd0);
        @(negedge clk);
        chk("hold_sum2", {28'b0, sum4}, 32'he);

        rst = 1'b1;
        a4 = 4'hf; b4 = 4'hf; cin4 = 1'b1; v4 = 1'b1;
        @(negedge clk);
        rst = 1'b0; v4 = 1'b0;
        chk("mrst_sum", {28'b0, sum4}, 32'd0);
        chk("mrst_cout", {31'b0, cout4}, 32'd0);
        chk("mrst_valid", {31'b0, ov4}, 32'd0);

        for (int i = 0; i < 512; i++) begin
            idx = 9'(i);
            drive4(idx[8:5], idx[4:1], idx[0],
                   model({12'b0, idx[8:5]}, {12'b0, idx[4:1]}, idx[0], 4));
        end
        @(negedge clk);
        v4 = 1'b0;

        drive16(16'hffff, 16'h0000, 1'b1);
        drive16(16'hffff, 16'h0001, 1'b0);
        drive16(16'h0fff, 16'h0001, 1'b0);
        drive16(16'h00ff, 16'hff00, 1'b1);
        drive16(16'h7fff, 16'h0001, 1'b0);
        drive16(16'h8000, 16'h8000, 1'b0);
        drive16(16'hf0f0, 16'h0f0f, 1'b1);
        drive16(16'h0000, 16'h0000, 1'b0);
        for (int i = 0; i < 200; i++) begin
            drive16(16'($urandom), 16'($urandom), 1'($urandom));
        end
        @(negedge clk);
        v16 = 1'b0;

        repeat (3) @(negedge clk);
        chk("q4_drain", q4.size(), 32'd0);
        chk("q16_drain", q16.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
